mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 1: cycles from mem_en high to mem_rdata valid; legal range 1..4.
REQ-002 SHALL have parameter STARVE, default 3: the maximum number of consecutive D grants while i_req is pending.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_req  in  1  instruction-fetch request; held high until i_done.
REQ-006 i_addr  in  32  fetch byte address; stable while i_req is high.
REQ-007 i_rdata  out  32  fetched word; registered.
REQ-008 i_done  out  1  one-cycle completion pulse for the fetch port.
REQ-009 d_req  in  1  data request; held high until d_done.
REQ-010 d_we  in  1  1=store, 0=load; stable while d_req is high.
REQ-011 d_addr  in  32  data byte address; stable while d_req is high.
REQ-012 d_wdata  in  32  store data; stable while d_req is high.
REQ-013 d_rdata  out  32  load word; registered.
REQ-014 d_done  out  1  one-cycle completion pulse for the data port.
REQ-015 mem_en  out  1  single-port memory command strobe.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_addr  out  32  word-aligned memory address.
REQ-018 mem_wdata  out  32  memory write data.
REQ-019 mem_rdata  in  32  memory read data, valid LAT cycles after mem_en.
REQ-020 busy  out  1  high whenever the state is not IDLE.

Function
REQ-021 SHALL implement the FSM IDLE -> ISSUE -> WAIT (LAT cycles) -> DONE -> IDLE, with exactly one access in flight.
REQ-022 IDLE with neither request SHALL stay in IDLE; with any request it SHALL register the owner and command and go to ISSUE.
REQ-023 Requests SHALL be sampled only in IDLE; requests raised in any other state wait until IDLE.
REQ-024 With only one request high, that port SHALL win.
REQ-025 With both requests high, D SHALL win unless starve_cnt==STARVE, in which case I SHALL win.
REQ-026 starve_cnt (width covering 0..STARVE) SHALL update on each grant as follows:
- increment on a D grant while i_req is high;
- clear on any I grant;
- hold otherwise;
- never exceed STARVE.
REQ-027 mem_en SHALL be high only in ISSUE.
REQ-028 mem_we SHALL equal owner==D and d_we, and only in ISSUE; the I port never writes.
REQ-029 mem_addr SHALL be {addr[31:2],2'b00} of the owner; mem_wdata SHALL be the registered d_wdata; both hold through WAIT.
REQ-030 The owner's rdata register SHALL capture mem_rdata on the last WAIT cycle; the other port's rdata SHALL hold its value.
REQ-031 For stores, d_rdata SHALL hold its old value; d_done SHALL still pulse.
REQ-032 The owner's done SHALL be high only in DONE, for exactly one cycle.
REQ-033 Latency: a request sampled in IDLE at cycle k SHALL produce ISSUE at k+1, done at k+2+LAT, and IDLE at k+3+LAT.
REQ-034 A requester SHALL deassert req or present a new request in the cycle after done; the arbiter SHALL not re-sample before IDLE.
REQ-035 i_done and d_done SHALL never both be high in the same cycle.

Reset
REQ-036 Asserting reset at any time SHALL immediately force the following:
- state=IDLE;
- starve_cnt=0;
- i_rdata=d_rdata=0;
- all strobes (mem_en, mem_we, i_done, d_done, busy) =0;
- mem_addr=mem_wdata=0.
REQ-037 Reset mid-operation SHALL abort the access with no done pulse; a store already issued in ISSUE is not retracted.
REQ-038 After reset deasserts, the first rising edge SHALL behave as IDLE sampling.

Verification
REQ-039 LAT=1, i_req alone with i_addr=0x0000_0102 sampled cycle 0 -> mem_en=1 with mem_addr=0x0000_0100 in cycle 1; mem_rdata=0xDEADBEEF in cycle 2; i_done=1 with i_rdata=0xDEADBEEF in cycle 3; busy=0 in cycle 4.
REQ-040 d_req with d_we=1, d_addr=0x800, d_wdata=0x55 -> one ISSUE cycle with mem_en=mem_we=1, mem_addr=0x800, mem_wdata=0x55; d_done pulses at k+3; d_rdata unchanged.
REQ-041 STARVE=3, both requests held continuously -> grant order D,D,D,I,D,D,D,I; i_done never coincides with d_done.
REQ-042 LAT=3, single load -> done exactly 5 cycles after the sampling edge; mem_en high for exactly 1 cycle.
REQ-043 Reset asserted in WAIT of a load -> outputs zero asynchronously; no d_done; the next request completes normally with starve_cnt=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, one access in flight.
// Done pulses LAT+2 cycles after the grant edge; requests wait, and are not sampled, until the FSM is back in IDLE.
module mem_arbiter #(
  parameter int LAT    = 1,
  parameter int STARVE = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int              SW         = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE);
  localparam logic [1:0]      LAT_LAST   = 2'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_owner_d;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_i_rdata;
  logic [31:0]   r_d_rdata;
  logic [1:0]    r_wcnt;
  logic [SW-1:0] r_starve;

  logic          w_req_any;
  logic          w_grant_d;
  logic          w_last_wait;
  logic [31:0]   w_sel_addr;

  assign w_req_any   = i_req | d_req;
  // Data wins a tie unless the fetch port has already waited STARVE data grants.
  assign w_grant_d   = d_req & (~i_req | (r_starve != STARVE_MAX));
  assign w_last_wait = (r_state == S_WAIT) && (r_wcnt == LAT_LAST);
  assign w_sel_addr  = w_grant_d ? d_addr : i_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_last_wait) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_wcnt    <= '0;
      r_starve  <= '0;
    end else begin
      if (r_state == S_IDLE && w_req_any) begin
        r_owner_d <= w_grant_d;
        r_we      <= w_grant_d & d_we;
        r_addr    <= w_sel_addr & 32'hFFFF_FFFC;
        r_wdata   <= d_wdata;
        if (!w_grant_d) begin
          r_starve <= '0;
        end else if (i_req && r_starve != STARVE_MAX) begin
          r_starve <= r_starve + 1'b1;
        end
      end

      if (r_state == S_ISSUE) begin
        r_wcnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt + 1'b1;
      end

      // Stores leave d_rdata untouched; only the owning port's register captures.
      if (w_last_wait) begin
        if (!r_owner_d) begin
          r_i_rdata <= mem_rdata;
        end else if (!r_we) begin
          r_d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (r_state == S_ISSUE);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign i_done    = (r_state == S_DONE) & ~r_owner_d;
  assign d_done    = (r_state == S_DONE) & r_owner_d;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule
